// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor.
// Stage 1 registers per-bit and per-group generate/propagate terms.
// Stage 2 resolves the group carries with a flattened lookahead, then
// registers the sum and the flags. Valid/ready handshakes sit on both sides.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready operand beat handshake (in_ready is combinational)
//   a, b, cin, sub    operands; sub=1 computes a-b (cin ignored)
//   out_valid/ready   result beat handshake
//   sum, cout, ovf    result, carry out of MSB, two's-complement overflow
//   pg, gg            word group-propagate / group-generate
module cla_pipe_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             pg,
  output logic             gg
);

  localparam int unsigned NGRP = WIDTH / 4;

  if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_width
    $error("cla_pipe_adder: WIDTH must be a multiple of 4 in the range 4..64");
  end

  // Stage 1 state
  logic [WIDTH-1:0] p_d, p_q, g_d, g_q;
  logic [NGRP-1:0]  gv_d, gv_q, pv_d, pv_q;
  logic             c0_d, c0_q, v1_d, v1_q;

  // Stage 2 state
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q, ovf_d, ovf_q, pg_d, pg_q, gg_d, gg_q;
  logic             v2_d, v2_q;

  logic             adv1, adv2;
  logic [WIDTH-1:0] be;
  logic [NGRP:0]    gc;
  logic [WIDTH-1:0] cb;
  logic             acc, prod, wgg;

  // A stage may take new contents when it is empty or its successor moves.
  assign adv2     = !v2_q || out_ready;
  assign adv1     = !v1_q || adv2;
  assign in_ready = adv1 && !rst;

  // Stage 1: operand preparation and group generate/propagate
  always_comb begin : s1_next
    be   = sub ? ~b : b;
    p_d  = p_q;
    g_d  = g_q;
    gv_d = gv_q;
    pv_d = pv_q;
    c0_d = c0_q;
    v1_d = v1_q;
    if (adv1) begin
      v1_d = in_valid;
      c0_d = sub | cin;
      g_d  = a & be;
      p_d  = a ^ be;
      for (int k = 0; k < int'(NGRP); k++) begin
        gv_d[k] = g_d[4*k+3]
                | (p_d[4*k+3] & g_d[4*k+2])
                | (p_d[4*k+3] & p_d[4*k+2] & g_d[4*k+1])
                | (p_d[4*k+3] & p_d[4*k+2] & p_d[4*k+1] & g_d[4*k]);
        pv_d[k] = &p_d[4*k +: 4];
      end
    end
  end

  // Stage 2: group carries as independent sum-of-products, then in-group carries
  always_comb begin : s2_carry
    gc    = '0;
    cb    = '0;
    acc   = 1'b0;
    prod  = 1'b0;
    wgg   = 1'b0;
    gc[0] = c0_q;
    for (int k = 0; k < int'(NGRP); k++) begin
      acc = 1'b0;
      for (int j = 0; j <= k; j++) begin
        prod = gv_q[j];
        for (int m = j + 1; m <= k; m++) prod = prod & pv_q[m];
        acc = acc | prod;
      end
      prod = c0_q;
      for (int m = 0; m <= k; m++) prod = prod & pv_q[m];
      gc[k+1] = acc | prod;
    end
    // acc now holds the carry out of the top group with a zero carry-in
    wgg = acc;
    for (int k = 0; k < int'(NGRP); k++) begin
      cb[4*k]   = gc[k];
      cb[4*k+1] = g_q[4*k] | (p_q[4*k] & gc[k]);
      cb[4*k+2] = g_q[4*k+1]
                | (p_q[4*k+1] & g_q[4*k])
                | (p_q[4*k+1] & p_q[4*k] & gc[k]);
      cb[4*k+3] = g_q[4*k+2]
                | (p_q[4*k+2] & g_q[4*k+1])
                | (p_q[4*k+2] & p_q[4*k+1] & g_q[4*k])
                | (p_q[4*k+2] & p_q[4*k+1] & p_q[4*k] & gc[k]);
    end
  end

  // Stage 2: result and flag registers
  always_comb begin : s2_next
    sum_d  = sum_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    pg_d   = pg_q;
    gg_d   = gg_q;
    v2_d   = v2_q;
    if (adv2) begin
      v2_d   = v1_q;
      sum_d  = p_q ^ cb;
      cout_d = gc[NGRP];
      ovf_d  = cb[WIDTH-1] ^ gc[NGRP];
      pg_d   = &pv_q;
      gg_d   = wgg;
    end
  end

  always_ff @(posedge clk) begin : regs
    if (rst) begin
      p_q    <= '0;
      g_q    <= '0;
      gv_q   <= '0;
      pv_q   <= '0;
      c0_q   <= 1'b0;
      v1_q   <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      pg_q   <= 1'b0;
      gg_q   <= 1'b0;
      v2_q   <= 1'b0;
    end else begin
      p_q    <= p_d;
      g_q    <= g_d;
      gv_q   <= gv_d;
      pv_q   <= pv_d;
      c0_q   <= c0_d;
      v1_q   <= v1_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      pg_q   <= pg_d;
      gg_q   <= gg_d;
      v2_q   <= v2_d;
    end
  end

  assign out_valid = v2_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign pg        = pg_q;
  assign gg        = gg_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: directed vectors at WIDTH 16/4/64, backpressure,
// reset mid-stall and a long random valid/ready run against an arithmetic model.
module tb_cla_pipe_adder;

  localparam int unsigned W = 16;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         pg;
    logic         gg;
  } res_t;

  typedef struct {
    res_t exp;
    int   acc;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=16 instance
  logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [W-1:0] a = '0, b = '0, sum;
  logic         cin = 1'b0, sub = 1'b0, cout, ovf, pg, gg;

  // WIDTH=4 instance
  logic       iv4 = 1'b0, ir4, ov4, or4 = 1'b1, c4 = 1'b0, s4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0, sum4;
  logic       cout4, ovf4, pg4, gg4;

  // WIDTH=64 instance
  logic        iv64 = 1'b0, ir64, ov64, or64 = 1'b1, c64 = 1'b0, s64 = 1'b0;
  logic [63:0] a64 = '0, b64 = '0, sum64;
  logic        cout64, ovf64, pg64, gg64;

  cla_pipe_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .pg(pg), .gg(gg)
  );

  cla_pipe_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4),
    .a(a4), .b(b4), .cin(c4), .sub(s4), .out_valid(ov4),
    .out_ready(or4), .sum(sum4), .cout(cout4), .ovf(ovf4), .pg(pg4), .gg(gg4)
  );

  cla_pipe_adder #(.WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64),
    .a(a64), .b(b64), .cin(c64), .sub(s64), .out_valid(ov64),
    .out_ready(or64), .sum(sum64), .cout(cout64), .ovf(ovf64), .pg(pg64), .gg(gg64)
  );

  int           errors = 0;
  int           checks = 0;
  beat_t        q[$];
  logic [W-1:0] out_log[$];
  int           edge_cnt = 0;
  logic         just_reset = 1'b0;
  logic         m_vis, m_rdy, e_vis, e_rdy;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Plain arithmetic definition of the result and flags
  function automatic res_t ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic ci, input logic sb);
    logic [W-1:0] be;
    logic         c0;
    logic [W:0]   full, raw;
    res_t         r;
    be     = sb ? ~y : y;
    c0     = sb ? 1'b1 : ci;
    full   = {1'b0, x} + {1'b0, be} + (W+1)'(c0);
    raw    = {1'b0, x} + {1'b0, be};
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (x[W-1] == be[W-1]) && (full[W-1] != x[W-1]);
    r.pg   = ((x ^ be) == {W{1'b1}});
    r.gg   = raw[W];
    return r;
  endfunction

  // Model: a 2-deep in-order queue; a beat is visible one edge after acceptance
  always @(posedge clk) begin
    m_vis = (q.size() > 0) && (q[0].acc < edge_cnt);
    m_rdy = !rst && ((q.size() < 2) || out_ready);
    edge_cnt++;
    if (rst) begin
      q.delete();
    end else begin
      if (m_vis && out_ready) void'(q.pop_front());
      if (in_valid && m_rdy) q.push_back('{exp: ref_model(a, b, cin, sub), acc: edge_cnt});
    end
    if (!rst && out_valid && out_ready) out_log.push_back(sum);
    just_reset = rst;
  end

  // Compare process
  initial forever begin
    @(negedge clk);
    if (edge_cnt > 0) begin
      e_vis = (q.size() > 0) && (q[0].acc < edge_cnt);
      e_rdy = !rst && ((q.size() < 2) || out_ready);
      chk("out_valid", 80'(out_valid), 80'(e_vis));
      chk("in_ready", 80'(in_ready), 80'(e_rdy));
      if (e_vis && out_valid) chk("result", 80'({sum, cout, ovf, pg, gg}), 80'(q[0].exp));
      if (just_reset) chk("reset_outputs", 80'({out_valid, sum, cout, ovf, pg, gg}), 80'(0));
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic ci, input logic sb);
    logic got;
    got = 1'b0;
    a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
      step();
    end
    in_valid = 1'b0;
    if (!got) chk("send_timeout", 80'(got), 80'(1));
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return W'($urandom);
    endcase
  endfunction

  logic [W-1:0] va[5], vb[5];
  logic         vci[5], vsb[5];
  logic [19:0]  vexp[5];
  int           log0, accepted;

  initial begin
    va[0] = 16'hFFFF; vb[0] = 16'h0001; vci[0] = 1'b0; vsb[0] = 1'b0; vexp[0] = {16'h0000, 4'b1001};
    va[1] = 16'h7FFF; vb[1] = 16'h0001; vci[1] = 1'b0; vsb[1] = 1'b0; vexp[1] = {16'h8000, 4'b0100};
    va[2] = 16'h0005; vb[2] = 16'h0007; vci[2] = 1'b1; vsb[2] = 1'b1; vexp[2] = {16'hFFFE, 4'b0000};
    va[3] = 16'h8000; vb[3] = 16'h0001; vci[3] = 1'b0; vsb[3] = 1'b1; vexp[3] = {16'h7FFF, 4'b1101};
    va[4] = 16'hAAAA; vb[4] = 16'h5555; vci[4] = 1'b1; vsb[4] = 1'b0; vexp[4] = {16'h0000, 4'b1010};

    repeat (3) step();
    rst = 1'b0;

    // Directed vectors: pin the model, then the DUT, including two-edge latency
    for (int i = 0; i < 5; i++) begin
      chk("model_pin", 80'(ref_model(va[i], vb[i], vci[i], vsb[i])), 80'(vexp[i]));
      send(va[i], vb[i], vci[i], vsb[i]);
      @(negedge clk);
      chk("latency_early", 80'(out_valid), 80'(0));
      step();
      @(negedge clk);
      chk("latency_on", 80'(out_valid), 80'(1));
      chk("directed_result", 80'({sum, cout, ovf, pg, gg}), 80'(vexp[i]));
      step();
    end

    // WIDTH=4 and WIDTH=64 corner cases
    a4 = 4'h7; b4 = 4'h1; iv4 = 1'b1;
    a64 = '1; b64 = '0; c64 = 1'b1; iv64 = 1'b1;
    @(negedge clk);
    chk("w4_in_ready", 80'(ir4), 80'(1));
    chk("w64_in_ready", 80'(ir64), 80'(1));
    step();
    iv4 = 1'b0; iv64 = 1'b0;
    @(negedge clk);
    chk("w4_early", 80'(ov4), 80'(0));
    step();
    @(negedge clk);
    chk("w4_valid", 80'(ov4), 80'(1));
    chk("w4_result", 80'({sum4, cout4, ovf4, pg4, gg4}), 80'({4'h8, 4'b0100}));
    chk("w64_valid", 80'(ov64), 80'(1));
    chk("w64_result", 80'({sum64, cout64, ovf64, pg64, gg64}), 80'({64'h0, 4'b1010}));
    step();

    // Backpressure: two beats buffered, third refused until out_ready rises
    out_ready = 1'b0;
    log0 = out_log.size();
    send(16'd1, 16'd1, 1'b0, 1'b0);
    send(16'd2, 16'd2, 1'b0, 1'b0);
    a = 16'd3; b = 16'd3; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 80'(in_ready), 80'(0));
      chk("bp_out_valid", 80'(out_valid), 80'(1));
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_shift_ready", 80'(in_ready), 80'(1));
    step();
    in_valid = 1'b0;
    repeat (6) step();
    chk("bp_count", 80'(out_log.size() - log0), 80'(3));
    if (out_log.size() - log0 == 3) begin
      chk("bp_order0", 80'(out_log[log0]), 80'(2));
      chk("bp_order1", 80'(out_log[log0+1]), 80'(4));
      chk("bp_order2", 80'(out_log[log0+2]), 80'(6));
    end

    // Reset with both stages full and output stalled
    out_ready = 1'b0;
    send(16'd9, 16'd9, 1'b0, 1'b0);
    send(16'd10, 16'd10, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 80'(in_ready), 80'(0));
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_outputs", 80'({out_valid, sum, cout, ovf, pg, gg}), 80'(0));
    chk("rst_release_ready", 80'(in_ready), 80'(1));
    log0 = out_log.size();
    out_ready = 1'b1;
    repeat (5) step();
    chk("rst_no_ghosts", 80'(out_log.size() - log0), 80'(0));

    // Random valid/ready traffic
    accepted = 0;
    for (int cyc = 0; cyc < 60000 && accepted < 10000; cyc++) begin
      in_valid  = ($urandom_range(0, 99) < 70);
      a         = rnd_op();
      b         = rnd_op();
      cin       = 1'($urandom);
      sub       = 1'($urandom);
      out_ready = ($urandom_range(0, 99) < 65);
      @(negedge clk);
      if (in_valid && in_ready) accepted++;
      step();
    end
    in_valid = 1'b0;
    chk("random_beats", 80'(accepted), 80'(10000));
    out_ready = 1'b1;
    repeat (4) step();
    chk("drained", 80'(q.size()), 80'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, two-stage pipelined carry-lookahead adder/subtractor. Successor to the team's 4-bit CLA cell.
- Word is split into 4-bit lookahead groups.
- Stage 1 registers per-group generate/propagate. Stage 2 resolves group carries by lookahead and registers sum and flags.
- Valid/ready handshakes on both sides. Used as the ALU add path where WIDTH > 4 and timing needs a pipeline cut.

Parameters:
- WIDTH, 16: operand width in bits. Must be a multiple of 4, range 4..64. Otherwise elaboration fails.
- NGRP, WIDTH/4: number of 4-bit lookahead groups. Derived; not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat present
- in_ready  out  1  block can accept a beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in. Ignored when sub=1.
- sub  in  1  0: A+B+cin; 1: A-B, i.e. A+~B+1
- out_valid  out  1  result beat present
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB. When sub=1: 1 means no borrow.
- ovf  out  1  two's-complement overflow
- pg  out  1  word group-propagate: AND of all bit propagates
- gg  out  1  word group-generate: carry-out assuming carry-in 0

Behaviour:
- Operand preparation: be = sub ? ~b : b; c0 = sub ? 1 : cin.
- Bit level: g[i] = a[i]&be[i]; p[i] = a[i]^be[i].
- Per group k: GG_k and PG_k use the 4-bit lookahead equations.
- Stage 1 register holds: p, g, GG/PG vectors, c0, valid flag v1.
- Stage 2, group carries: C_0 = c0; C_{k+1} = GG_k | (PG_k & C_k). Implemented as a flattened lookahead across groups, not a ripple chain in time.
- Stage 2, in-group carries use the 4-bit lookahead from C_k; sum[i] = p[i] ^ c[i].
- Flags:
  - cout = C_NGRP.
  - ovf = c[WIDTH-1] ^ cout.
  - pg = AND of all PG_k.
  - gg = word group-generate, independent of c0.
- Stage 2 register holds sum, cout, ovf, pg, gg, valid v2. All outputs are driven directly from stage-2 flops.
- Handshake:
  - Input transfer when in_valid & in_ready. Output transfer when out_valid & out_ready.
  - adv2 = !v2 | out_ready; adv1 = !v1 | adv2.
  - in_ready = adv1 & !rst. Combinational; no dependency on in_valid.
  - Stage 2 loads from stage 1 when adv2; v2 <= v1. Stage 1 loads when adv1; v1 <= in_valid.
  - While stalled, stage contents are held unchanged and out_valid stays high.
- Latency: a beat accepted at clock edge k appears with out_valid=1 after edge k+1 when not stalled.
- Throughput: 1 beat/cycle sustained.
- Capacity: 2 beats buffered when out_ready=0.
- Ordering: strictly in order; no beat dropped or duplicated.
- Reset (rst=1 at an edge):
  - v1=v2=0.
  - sum=0, cout=0, ovf=0, pg=0, gg=0, so out_valid=0.
  - In-flight beats are discarded, including mid-stall.
  - in_ready=0 while rst is high; it is 1 in the first cycle after release.
- Simultaneous accept and emit with both stages full and out_ready=1: the pipeline shifts by one and a new beat is accepted the same cycle.
- Data registers may load on every advance regardless of valid. Only valid beats are observable.

Test Plan (WIDTH=16 unless noted):
- a=FFFF, b=0001, cin=0, sub=0 -> sum=0000, cout=1, ovf=0, pg=0, gg=1; out_valid exactly 2 edges after accept.
- a=7FFF, b=0001, sub=0 -> sum=8000, cout=0, ovf=1; repeat with WIDTH=4, a=7, b=1 -> sum=8, ovf=1.
- sub=1, a=0005, b=0007, cin=1 (ignored) -> sum=FFFE, cout=0, ovf=0. Then a=8000, b=0001 -> sum=7FFF, cout=1, ovf=1.
- a=AAAA, b=5555, cin=1 -> sum=0000, cout=1, pg=1, gg=0. Full-chain propagate; also run at WIDTH=64 with all-ones vs 0, cin=1.
- Backpressure: out_ready=0, offer beats 1+1, 2+2, 3+3. Required: first two accepted, then in_ready=0. Raise out_ready: sums 2, 4, 6 in order, each once. Then random valid/ready for 10k beats vs reference model.
- Reset with both stages full and out_ready=0 -> next cycle out_valid=0 and all outputs 0. Old beats never emerge. in_ready=1 the cycle after rst drops.
